ex_result_pipe: RTL

Carries EX-stage results (destination address, write enable, write data) through the MEM and WB pipeline registers and commits them to the 32×32 general register file. It sits between the EX stage and ID. It provides two read ports to ID, with operand forwarding from every in-flight result. Stall and flush inputs come from the pipeline control block.

---
 rtl/ex_result_pipe_if.sv | 43 ++++
 rtl/ex_result_pipe.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ex_result_pipe_if.sv
// Bundle between the EX/ID/control side and ex_result_pipe.
// master: drives EX result, stall/flush, read requests; sees read data and
//         MEM/WB stage contents. slave: the result pipe itself.
interface ex_result_pipe_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] ex_wd_i;
    logic          ex_wreg_i;
    logic [DW-1:0] ex_wdata_i;
    logic [1:0]    stall_i;
    logic          flush_i;
    logic          re1_i;
    logic          re2_i;
    logic [AW-1:0] raddr1_i;
    logic [AW-1:0] raddr2_i;
    logic [DW-1:0] rdata1_o;
    logic [DW-1:0] rdata2_o;
    logic [AW-1:0] mem_wd_o;
    logic          mem_wreg_o;
    logic [DW-1:0] mem_wdata_o;
    logic [AW-1:0] wb_wd_o;
    logic          wb_wreg_o;
    logic [DW-1:0] wb_wdata_o;

    modport master (
        output ex_wd_i, ex_wreg_i, ex_wdata_i,
        output stall_i, flush_i,
        output re1_i, re2_i, raddr1_i, raddr2_i,
        input  rdata1_o, rdata2_o,
        input  mem_wd_o, mem_wreg_o, mem_wdata_o,
        input  wb_wd_o, wb_wreg_o, wb_wdata_o
    );

    modport slave (
        input  ex_wd_i, ex_wreg_i, ex_wdata_i,
        input  stall_i, flush_i,
        input  re1_i, re2_i, raddr1_i, raddr2_i,
        output rdata1_o, rdata2_o,
        output mem_wd_o, mem_wreg_o, mem_wdata_o,
        output wb_wd_o, wb_wreg_o, wb_wdata_o
    );
endinterface

// File: rtl/ex_result_pipe.sv
// EX result -> MEM reg -> WB reg -> 32x32 register file, with two
// combinational read ports for ID.
// Ports: clk, rst (async, active high), bus (ex_result_pipe_if.slave):
//   ex_* result in, stall_i/flush_i control, re/raddr read requests,
//   rdata read data, mem_*/wb_* stage register contents.
// Option: define RESULT_PIPE_FWD_EN for EX > MEM > WB > array forwarding;
//   otherwise reads return the array contents only.
module ex_result_pipe #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    ex_result_pipe_if.slave   bus
);
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
    } res_t;

    localparam res_t BUBBLE = '0;

    res_t ex_res;
    res_t mem_q;
    res_t mem_d;
    res_t wb_q;
    res_t wb_d;

    logic [DW-1:0] regs [DEPTH];

    assign ex_res.wd    = bus.ex_wd_i;
    assign ex_res.wreg  = bus.ex_wreg_i;
    assign ex_res.wdata = bus.ex_wdata_i;

    // Flush beats stall; EX stalled alone means MEM receives a bubble,
    // both stalled means MEM keeps its result.
    always_comb begin
        mem_d = ex_res;
        priority case (1'b1)
            bus.flush_i:                       mem_d = BUBBLE;
            bus.stall_i[0] && !bus.stall_i[1]: mem_d = BUBBLE;
            bus.stall_i[0] && bus.stall_i[1]:  mem_d = mem_q;
            default:                           mem_d = ex_res;
        endcase
    end

    always_comb begin
        wb_d = mem_q;
        priority case (1'b1)
            bus.flush_i:    wb_d = BUBBLE;
            bus.stall_i[1]: wb_d = BUBBLE;
            default:        wb_d = mem_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // r0 is hardwired zero, so its writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_q.wreg && (wb_q.wd != '0)) begin
            regs[wb_q.wd] <= wb_q.wdata;
        end
    end

    assign bus.mem_wd_o    = mem_q.wd;
    assign bus.mem_wreg_o  = mem_q.wreg;
    assign bus.mem_wdata_o = mem_q.wdata;
    assign bus.wb_wd_o     = wb_q.wd;
    assign bus.wb_wreg_o   = wb_q.wreg;
    assign bus.wb_wdata_o  = wb_q.wdata;

`ifdef RESULT_PIPE_FWD_EN
    // Youngest matching in-flight result wins over the array.
    function automatic logic [DW-1:0] rd_port(
        input logic          re,
        input logic [AW-1:0] a,
        input res_t          ex,
        input res_t          mem,
        input res_t          wb,
        input logic [DW-1:0] arr
    );
        logic [DW-1:0] r;
        r = arr;
        priority case (1'b1)
            !re || (a == '0):        r = '0;
            ex.wreg  && ex.wd == a:  r = ex.wdata;
            mem.wreg && mem.wd == a: r = mem.wdata;
            wb.wreg  && wb.wd == a:  r = wb.wdata;
            default:                 r = arr;
        endcase
        return r;
    endfunction

    assign bus.rdata1_o = rd_port(bus.re1_i, bus.raddr1_i, ex_res, mem_q,
                                  wb_q, regs[bus.raddr1_i]);
    assign bus.rdata2_o = rd_port(bus.re2_i, bus.raddr2_i, ex_res, mem_q,
                                  wb_q, regs[bus.raddr2_i]);
`else
    // No bypass: ID must stall until the result reaches the array.
    assign bus.rdata1_o = (bus.re1_i && (bus.raddr1_i != '0))
                        ? regs[bus.raddr1_i] : '0;
    assign bus.rdata2_o = (bus.re2_i && (bus.raddr2_i != '0))
                        ? regs[bus.raddr2_i] : '0;
`endif

endmodule
